rr_handshake_arbiter: RTL



---
 rtl/handshake_pkg.sv | 21 ++
 rtl/rr_handshake_arbiter_pick.sv | 35 +++
 rtl/rr_handshake_arbiter.sv | 67 ++++++
 3 files changed

// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake fabric: index-width helpers and
// reset constants reused by every arbiter in the top level.
package handshake_pkg;

   localparam int unsigned PTR_RESET = 0;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r = r + 1;
      return r;
   endfunction

   // A single requester still needs a 1-bit index port.
   function automatic int unsigned src_width(input int unsigned n);
      int unsigned c;
      c = clog2(n);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/rr_handshake_arbiter_pick.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N, as a one-hot grant plus its binary index.
module rr_pick
   import handshake_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned SRC_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [SRC_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [SRC_W-1:0] idx,
   output logic             any
);

   logic found;

   // Outer loop walks search order; inner loop keeps every select constant.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (!found && (i == (32'(ptr) + k) % N) && req[i]) begin
               found    = 1'b1;
               grant[i] = 1'b1;
               idx      = SRC_W'(i);
            end
         end
      end
      any = found;
   end

endmodule

// File: rtl/rr_handshake_arbiter.sv
// N-to-1 round-robin arbiter with a forward-registered ready/valid output
// stage; ready back to the masters is combinational from the slave ready.
module rr_handshake_arbiter
   import handshake_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N-1:0]              m_valid,
   input  logic [N*WIDTH-1:0]        m_data,
   output logic [N-1:0]              m_ready,
   output logic                      s_valid,
   output logic [WIDTH-1:0]          s_data,
   output logic [src_width(N)-1:0]   s_src,
   input  logic                      s_ready
);

   localparam int unsigned SRC_W = src_width(N);

   logic [SRC_W-1:0] ptr;
   logic [N-1:0]     grant;
   logic [SRC_W-1:0] g_idx;
   logic             any;
   logic             load;
   logic [WIDTH-1:0] g_data;

   rr_pick #(
      .N     (N),
      .SRC_W (SRC_W)
   ) u_pick (
      .req   (m_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (g_idx),
      .any   (any)
   );

   assign load    = (~s_valid | s_ready) & any & ~rst;
   assign m_ready = load ? grant : '0;

   always_comb begin
      g_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant[i]) g_data = m_data[i*WIDTH +: WIDTH];
      end
   end

   // A load while draining overwrites the held word, keeping s_valid high.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_valid <= 1'b0;
         s_data  <= '0;
         s_src   <= '0;
         ptr     <= SRC_W'(PTR_RESET);
      end else if (load) begin
         s_valid <= 1'b1;
         s_data  <= g_data;
         s_src   <= g_idx;
         ptr     <= (g_idx == SRC_W'(N - 1)) ? '0 : g_idx + SRC_W'(1);
      end else if (s_ready) begin
         s_valid <= 1'b0;
      end
   end

endmodule
